// File: rtl/nz_scanner_pkg.sv
// nz_scanner_pkg: shared FSM encoding and width helper for the nz_scanner block
package nz_scanner_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // Address width for a given depth, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nz_scanner_if.sv
// nz_scanner_if: scan request, register-file read port and output stream of nz_scanner
//   start/mode           scan request and flag select (0 nonzero, 1 positive)
//   nz_flags/pos_flags   per-entry flags from the register file
//   read_en/read_addr    register-file read port, read_data returns combinationally
//   out_valid/out_ready  output stream handshake carrying out_index/out_data/out_last
//   busy/done/nz_count   scan status
interface nz_scanner_if
    import nz_scanner_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int REG_DEPTH  = 64,
    parameter int ADDR_WIDTH = clog2(REG_DEPTH)
);
    logic                  start;
    logic                  mode;
    logic [REG_DEPTH-1:0]  nz_flags;
    logic [REG_DEPTH-1:0]  pos_flags;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [BIT_WIDTH-1:0]  read_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_index;
    logic [BIT_WIDTH-1:0]  out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   nz_count;

    modport master (
        output start, mode, nz_flags, pos_flags, read_data, out_ready,
        input  read_en, read_addr, out_valid, out_index, out_data, out_last, busy, done, nz_count
    );

    modport slave (
        input  start, mode, nz_flags, pos_flags, read_data, out_ready,
        output read_en, read_addr, out_valid, out_index, out_data, out_last, busy, done, nz_count
    );
endinterface

// File: rtl/nz_scanner_lowest_one_enc.sv
// lowest_one_enc: index of the lowest set bit of vec
//   vec    input vector
//   idx    position of the lowest set bit, 0 when vec is zero
//   found  vec has at least one set bit
module lowest_one_enc
    import nz_scanner_pkg::*;
#(
    parameter int REG_DEPTH  = 64,
    parameter int ADDR_WIDTH = clog2(REG_DEPTH)
) (
    input  logic [REG_DEPTH-1:0]  vec,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  found
);
    // Walking downward lets the lowest set bit be the last one to win.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = REG_DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = ADDR_WIDTH'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/nz_scanner.sv
// nz_scanner: streams index/value of every flagged register-file entry in ascending order
//   clk, rst  clock and synchronous active-high reset
//   bus       nz_scanner_if slave: scan request, register-file read port, output stream, status
module nz_scanner
    import nz_scanner_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int REG_DEPTH  = 64,
    parameter int ADDR_WIDTH = clog2(REG_DEPTH)
) (
    input logic         clk,
    input logic         rst,
    nz_scanner_if.slave bus
);
    state_t                state_q, state_d;
    logic [REG_DEPTH-1:0]  mask_q, mask_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
    logic [BIT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [ADDR_WIDTH:0]   nz_count_q, nz_count_d;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  found;
    logic                  can_take;
    logic                  issue;
    logic [REG_DEPTH-1:0]  rest;

    lowest_one_enc #(
        .REG_DEPTH (REG_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_enc (
        .vec  (mask_q),
        .idx  (idx),
        .found(found)
    );

    // Output register is free when empty or being drained this cycle.
    assign can_take = !out_valid_q || bus.out_ready;
    assign issue    = (state_q == SCAN) && found && can_take;
    // Clearing the lowest set bit leaves exactly the entries still to be emitted.
    assign rest     = mask_q & (mask_q - REG_DEPTH'(1));

    assign bus.read_en   = issue;
    assign bus.read_addr = issue ? idx : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.nz_count  = nz_count_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        nz_count_d  = nz_count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SCAN;
                    mask_d     = bus.mode ? bus.pos_flags : bus.nz_flags;
                    nz_count_d = '0;
                end
            end
            SCAN: begin
                if (issue) begin
                    out_valid_d = 1'b1;
                    out_index_d = idx;
                    out_data_d  = bus.read_data;
                    out_last_d  = rest == '0;
                    mask_d      = rest;
                    nz_count_d  = nz_count_q + (ADDR_WIDTH + 1)'(1);
                end else if (can_take) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            nz_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            nz_count_q  <= nz_count_d;
        end
    end
endmodule

// File: doc/nz_scanner.md
NZ_SCANNER -- requirements
Module: nz_scanner

Interface
REQ-001 Parameters SHALL be, one per line: BIT_WIDTH, default 16, entry width; REG_DEPTH, default 64, register-file depth; ADDR_WIDTH, default ceil(log2(REG_DEPTH)), address width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
REQ-003 clk  in  1  system clock; single clock domain, all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  one-cycle scan request.
REQ-006 mode  in  1  sampled with start: 0 selects nonzero flags, 1 selects positive flags.
REQ-007 nz_flags, pos_flags  in  REG_DEPTH each  per-entry nonzero and positive flags from the register file.
REQ-008 read_en  out  1  register-file read enable.
REQ-009 read_addr  out  ADDR_WIDTH  register-file read address.
REQ-010 read_data  in  BIT_WIDTH  combinational register-file read data.
REQ-011 out_valid, out_ready  out, in  1 each  output stream handshake.
REQ-012 out_index  out  ADDR_WIDTH  index of the emitted entry.
REQ-013 out_data  out  BIT_WIDTH  value of the emitted entry.
REQ-014 out_last  out  1  marks the final entry of a scan.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  one-cycle pulse at scan completion.
REQ-017 nz_count  out  ADDR_WIDTH+1  number of entries emitted by the last scan.

Function
REQ-018 FSM SHALL have states IDLE, SCAN, DONE.
REQ-019 In IDLE, start SHALL load mask <= (mode ? pos_flags : nz_flags), clear nz_count, and enter SCAN on the next edge.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 In SCAN, when mask != 0 and (!out_valid || out_ready): read_en=1 and read_addr = lowest set index of mask, both combinational in that cycle.
REQ-022 On that edge: out_valid<=1; out_index<=idx; out_data<=read_data; out_last<=(remaining mask==0); mask bit idx cleared; nz_count incremented.
REQ-023 When out_valid && out_ready and no new entry is issued, out_valid SHALL fall on the next edge.
REQ-024 Throughput SHALL be one entry per cycle while out_ready is held high; first out_valid SHALL appear 2 cycles after start.
REQ-025 out_index, out_data and out_last SHALL stay stable while out_valid && !out_ready.
REQ-026 SCAN SHALL go to DONE when mask==0 and the output buffer is empty or draining in that cycle.
REQ-027 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-028 An empty mask SHALL produce no output beats, pass through SCAN to DONE, and leave nz_count=0.
REQ-029 When read_en=0, read_addr SHALL be 0.
REQ-030 Flags SHALL be a snapshot taken at start; data SHALL be read live, including register-file write bypass.
REQ-031 Indices SHALL be emitted in strictly ascending order, each exactly once.

Reset
REQ-032 rst SHALL force IDLE, mask=0, out_valid=0, out_index=0, out_data=0, out_last=0, done=0, nz_count=0, read_en=0.
REQ-033 rst asserted mid-scan SHALL abort the scan with no done pulse; rst SHALL take priority over start.

Structure
REQ-034 The clog2 function and the FSM state encodings SHALL be placed in the shared package or include.
REQ-035 Lowest-set-bit search SHALL be a sub-module lowest_one_enc, parameterised by REG_DEPTH, with outputs idx and found.

Verification
REQ-036 Flags 0x...0000_8011 with mode=0 and out_ready=1 -> beats at indices 0, 4, 15 on consecutive cycles with matching data; out_last on index 15; done one cycle later; nz_count=3.
REQ-037 All flags zero -> no out_valid, done within 3 cycles of start, nz_count=0.
REQ-038 mode=1 with entries 2=0x0005 and 3=0xFFFB -> single beat at index 2, out_last=1.
REQ-039 out_ready toggled 1,0,0,1 during a 3-entry scan -> outputs stable while stalled, no loss or duplication.
REQ-040 rst pulsed one cycle after the first beat of a 64-entry full scan -> IDLE, out_valid=0, no done pulse; a new start then scans all 64 entries.
REQ-041 start re-pulsed mid-scan -> ignored; beat count unchanged.
